// File: rtl/uart_pkg.sv
// Shared UART definitions: launch-sequencer state encoding and the default byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        TXQ_IDLE,
        TXQ_LAUNCH,
        TXQ_WAIT_ACK,
        TXQ_WAIT_DONE
    } txq_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-push and transmitter-handshake signals of the UART transmit queue.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16
) ();

    logic                     wr_en;
    logic [DATA_W-1:0]        wr_data;
    logic                     flush;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     tx_busy;
    logic                     tx_send;
    logic [DATA_W-1:0]        tx_data;

    // Host logic plus transmitter: drives pushes and the busy handshake.
    modport master (
        output wr_en, wr_data, flush, tx_busy,
        input  full, empty, count, overflow, tx_send, tx_data
    );

    modport slave (
        input  wr_en, wr_data, flush, tx_busy,
        output full, empty, count, overflow, tx_send, tx_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with explicit occupancy counter and registered flags.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    input  logic                   flush,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a byte.
    assign pop     = rd_en && !empty && !flush;
    assign push    = wr_en && !flush && (!full || pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    // NOTE: storage has no reset; pointers and count make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && !flush && full && !pop;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                full   <= 1'b0;
                empty  <= 1'b1;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count_next;
                full  <= (count_next == DEPTH_C);
                empty <= (count_next == '0);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue and launch sequencer: pops one byte, strobes tx_send, waits out the busy handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rstn,
    uart_tx_fifo_if.slave  bus
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    txq_state_t        state;
    txq_state_t        state_next;
    logic [TW-1:0]     ack_cnt;
    logic [TW-1:0]     ack_cnt_next;
    logic              pop;
    logic [DATA_W-1:0] head;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (bus.wr_en),
        .wr_data  (bus.wr_data),
        .rd_en    (pop),
        .flush    (bus.flush),
        .rd_data  (head),
        .full     (bus.full),
        .empty    (bus.empty),
        .count    (bus.count),
        .overflow (bus.overflow)
    );

    always_comb begin
        state_next   = state;
        ack_cnt_next = ack_cnt;
        pop          = 1'b0;
        case (state)
            // A busy transmitter (frame started elsewhere) or a flush holds off the pop.
            TXQ_IDLE: begin
                if (!bus.empty && !bus.tx_busy && !bus.flush) begin
                    pop        = 1'b1;
                    state_next = TXQ_LAUNCH;
                end
            end
            TXQ_LAUNCH: begin
                ack_cnt_next = '0;
                state_next   = TXQ_WAIT_ACK;
            end
            // On timeout the byte is treated as sent; it is not retried.
            TXQ_WAIT_ACK: begin
                if (bus.tx_busy)
                    state_next = TXQ_WAIT_DONE;
                else if (ack_cnt == TW'(ACK_TIMEOUT))
                    state_next = TXQ_IDLE;
                else
                    ack_cnt_next = ack_cnt + TW'(1);
            end
            TXQ_WAIT_DONE: begin
                if (!bus.tx_busy)
                    state_next = TXQ_IDLE;
            end
            default: state_next = TXQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= TXQ_IDLE;
            ack_cnt     <= '0;
            bus.tx_send <= 1'b0;
            bus.tx_data <= '0;
        end else begin
            state       <= state_next;
            ack_cnt     <= ack_cnt_next;
            bus.tx_send <= (state_next == TXQ_LAUNCH);
            if (pop)
                bus.tx_data <= head;
        end
    end

endmodule
